// File: rtl/vec_mag_iter.sv
// Iterative 2-D vector magnitude: sumsq = x^2 + y^2 in one cycle, then a
// restoring square root that resolves one root bit per cycle, floor or rounded.
module vec_mag_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           round_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W:0]     mag,
  output logic [2*W:0]   sumsq
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    ROOT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    y_q;
  logic            rnd_q;
  logic [2*W+1:0]  rad_q;
  logic [W:0]      root_q;
  logic [W+2:0]    rem_q;
  logic [CW-1:0]   cnt_q;
  logic [W:0]      mag_q;
  logic [2*W:0]    sumsq_q;
  logic            out_valid_q;
  logic            in_ready_q;

  logic [2*W:0]    xe_s;
  logic [2*W:0]    ye_s;
  logic [2*W:0]    sq_s;
  logic [W+2:0]    rem_sh_s;
  logic [W+2:0]    trial_s;
  logic [W+2:0]    rem_nx_s;
  logic [W:0]      root_nx_s;
  logic            rnd_up_s;

  // Sum of squares and one restoring-sqrt digit step
  always_comb begin
    xe_s      = {{(W+1){1'b0}}, x_q};
    ye_s      = {{(W+1){1'b0}}, y_q};
    sq_s      = xe_s * xe_s + ye_s * ye_s;
    rem_sh_s  = {rem_q[W:0], rad_q[2*W+1 -: 2]};
    trial_s   = {root_q, 2'b01};
    rem_nx_s  = rem_sh_s;
    root_nx_s = {root_q[W-1:0], 1'b0};
    if (rem_sh_s >= trial_s) begin
      rem_nx_s  = rem_sh_s - trial_s;
      root_nx_s = {root_q[W-1:0], 1'b1};
    end else begin
      rem_nx_s  = rem_sh_s;
      root_nx_s = {root_q[W-1:0], 1'b0};
    end
    // N > r^2 + r is exactly N >= (r + 0.5)^2 for integer N
    rnd_up_s = rnd_q && (rem_nx_s > {2'b00, root_nx_s});
  end

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      rnd_q       <= 1'b0;
      rad_q       <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      mag_q       <= '0;
      sumsq_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x;
            y_q        <= y;
            rnd_q      <= round_en;
            in_ready_q <= 1'b0;
            state_q    <= SQ;
          end else begin
            state_q    <= IDLE;
          end
        end
        SQ: begin
          sumsq_q <= sq_s;
          rad_q   <= {1'b0, sq_s};
          root_q  <= '0;
          rem_q   <= '0;
          cnt_q   <= CW'(W);
          state_q <= ROOT;
        end
        ROOT: begin
          rad_q  <= rad_q << 2;
          rem_q  <= rem_nx_s;
          root_q <= root_nx_s;
          if (cnt_q == '0) begin
            mag_q       <= root_nx_s + {{W{1'b0}}, rnd_up_s};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q     <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mag       = mag_q;
  assign sumsq     = sumsq_q;

endmodule

// File: tb/tb_vec_mag_iter.sv
// Directed bench for vec_mag_iter at W=8 and W=4 with hand-computed results.
module tb_vec_mag_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, round_en, out_valid, out_ready;
  logic [7:0]  x, y;
  logic [8:0]  mag;
  logic [16:0] sumsq;

  logic        in_valid4, in_ready4, round_en4, out_valid4, out_ready4;
  logic [3:0]  x4, y4;
  logic [4:0]  mag4;
  logic [8:0]  sumsq4;

  int n_vec  = 0;
  int n_miss = 0;

  vec_mag_iter #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .round_en(round_en), .out_valid(out_valid),
    .out_ready(out_ready), .mag(mag), .sumsq(sumsq)
  );

  vec_mag_iter #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .x(x4), .y(y4), .round_en(round_en4), .out_valid(out_valid4),
    .out_ready(out_ready4), .mag(mag4), .sumsq(sumsq4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic r, input int e_sum, input int e_mag);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    x = a; y = b; round_en = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd10);
    chk({tag, ".sumsq"}, 32'(sumsq), e_sum);
    chk({tag, ".mag"}, 32'(mag), e_mag);
    @(posedge clk); #1;
    chk({tag, ".done_1cyc"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic r, input int e_sum, input int e_mag);
    int lat;
    @(negedge clk);
    x4 = a; y4 = b; round_en4 = r; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd6);
    chk({tag, ".sumsq"}, 32'(sumsq4), e_sum);
    chk({tag, ".mag"}, 32'(mag4), e_mag);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic seen;
    rst_n = 1'b0;
    in_valid = 1'b0; x = 8'd0; y = 8'd0; round_en = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; x4 = 4'd0; y4 = 4'd0; round_en4 = 1'b0; out_ready4 = 1'b1;
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.mag", 32'(mag), 32'd0);
    chk("rst.sumsq", 32'(sumsq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    op8("v3_4", 8'd3, 8'd4, 1'b0, 25, 5);
    op8("v0_0", 8'd0, 8'd0, 1'b1, 0, 0);
    op8("vmax_fl", 8'd255, 8'd255, 1'b0, 130050, 360);
    op8("vmax_rn", 8'd255, 8'd255, 1'b1, 130050, 361);
    op8("v2_3_fl", 8'd2, 8'd3, 1'b0, 13, 3);
    op8("v2_3_rn", 8'd2, 8'd3, 1'b1, 13, 4);
    op8("v1_1_fl", 8'd1, 8'd1, 1'b0, 2, 1);
    op8("v1_1_rn", 8'd1, 8'd1, 1'b1, 2, 1);

    // Backpressure: result held 20 cycles while the next pair waits on in_valid
    @(negedge clk);
    out_ready = 1'b0;
    x = 8'd100; y = 8'd50; round_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 8'd6; y = 8'd8; round_en = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_mag", 32'(mag), 32'd111);
      chk("bp.hold_sumsq", 32'(sumsq), 32'd12500);
      chk("bp.hold_rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.rel_valid", 32'(out_valid), 32'd0);
    chk("bp.rel_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp.queued_acc", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.q_latency", 32'(lat), 32'd10);
    chk("bp.q_sumsq", 32'(sumsq), 32'd100);
    chk("bp.q_mag", 32'(mag), 32'd10);
    @(posedge clk); #1;

    // Reset in the middle of ROOT
    @(negedge clk);
    x = 8'd200; y = 8'd100; round_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.mag", 32'(mag), 32'd0);
    chk("mid_rst.sumsq", 32'(sumsq), 32'd0);
    chk("mid_rst.out_valid4", 32'(out_valid4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst.no_stale", 32'(seen), 32'd0);

    op8("post_rst", 8'd3, 8'd4, 1'b1, 25, 5);

    op4("w4_fl", 4'd15, 4'd15, 1'b0, 450, 21);
    op4("w4_rn", 4'd15, 4'd15, 1'b1, 450, 21);
    op4("w4_2_3", 4'd2, 4'd3, 1'b1, 13, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
